div_seq: RTL and testbench

Multi-cycle divide sequencer for the EX stage. It accepts DIV/DIVU operands from EX and runs a 32-iteration restoring division. While it runs, it asserts a stall request to the pipeline controller. It returns the 64-bit {remainder, quotient} result for the HI/LO write.

---
 rtl/div_seq_pkg.sv | 24 ++
 rtl/div_seq_if.sv | 22 ++
 rtl/div_seq_step.sv | 18 +
 rtl/div_seq.sv | 163 ++++++++++++++++
 tb/tb_div_seq.sv | 221 ++++++++++++++++++++++
 5 files changed

// File: rtl/div_seq_pkg.sv
// Shared encodings for the EX-stage divide sequencer: FSM states, handshake
// levels and the aluop codes EX decodes into a divide request.
package div_seq_pkg;

  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;

  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;

  localparam logic [7:0] EXE_DIV_OP  = 8'b0001_1010;
  localparam logic [7:0] EXE_DIVU_OP = 8'b0001_1011;

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

endpackage

// File: rtl/div_seq_if.sv
// EX <-> divider handshake bundle: operands and control in, HI/LO result,
// ready flag and stall request out.
interface div_seq_if;
  logic        signed_div_i;
  logic [31:0] opdata1_i;
  logic [31:0] opdata2_i;
  logic        start_i;
  logic        annul_i;
  logic [63:0] result_o;
  logic        ready_o;
  logic        stallreq_o;

  modport master (
    output signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    input  result_o, ready_o, stallreq_o
  );

  modport slave (
    input  signed_div_i, opdata1_i, opdata2_i, start_i, annul_i,
    output result_o, ready_o, stallreq_o
  );
endinterface

// File: rtl/div_seq_step.sv
// One restoring-division iteration. Work register layout:
// [64:32] partial remainder, [31:0] dividend bits still to consume / quotient.
module div_step (
  input  logic [64:0] i_work,
  input  logic [31:0] i_divisor,
  output logic [64:0] o_work
);
  logic [64:0] w_shift;
  logic [32:0] w_diff;
  logic        w_unused_msb;

  // The partial remainder always stays below the divisor, so bit 64 is
  // never set on entry and is discarded by the shift.
  assign w_unused_msb = i_work[64];
  assign w_shift      = {i_work[63:0], 1'b0};
  assign w_diff       = w_shift[64:32] - {1'b0, i_divisor};
  assign o_work       = w_diff[32] ? w_shift : {w_diff, w_shift[31:1], 1'b1};
endmodule

// File: rtl/div_seq.sv
// 32-iteration DIV/DIVU sequencer with pipeline stall request.
// Signed handling is compiled in only when DIV_SIGNED_EN is defined.
module div_seq
  import div_seq_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  div_seq_if.slave bus
);
  div_state_e  r_state;
  div_state_e  w_state_nxt;
  logic [4:0]  r_cnt;
  logic [64:0] r_work;
  logic [64:0] w_work_nxt;
  logic [31:0] r_divisor;
  logic [63:0] r_result;
  logic        r_ready;
  logic        w_accept;
  logic        w_stall;
  logic        w_latch;
  logic        w_iter;
  logic        w_done;
  logic        w_zero_done;
  logic        w_release;
  logic [31:0] w_dvd_mag;
  logic [31:0] w_dvs_mag;
  logic [31:0] w_quot;
  logic [31:0] w_rem;
  logic        w_unused_work_msb;

  assign w_accept = (bus.start_i == DivStart) && !bus.annul_i;

  div_step u_step (
    .i_work    (r_work),
    .i_divisor (r_divisor),
    .o_work    (w_work_nxt)
  );

  assign w_unused_work_msb = w_work_nxt[64];

`ifdef DIV_SIGNED_EN
  logic w_dvd_neg;
  logic w_dvs_neg;
  logic r_neg_q;
  logic r_neg_r;

  assign w_dvd_neg = bus.signed_div_i & bus.opdata1_i[31];
  assign w_dvs_neg = bus.signed_div_i & bus.opdata2_i[31];
  assign w_dvd_mag = w_dvd_neg ? neg32(bus.opdata1_i) : bus.opdata1_i;
  assign w_dvs_mag = w_dvs_neg ? neg32(bus.opdata2_i) : bus.opdata2_i;

  // Quotient sign follows operand-sign mismatch; remainder follows dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
    end else if (w_latch) begin
      r_neg_q <= w_dvd_neg ^ w_dvs_neg;
      r_neg_r <= w_dvd_neg;
    end
  end

  assign w_quot = r_neg_q ? neg32(w_work_nxt[31:0])  : w_work_nxt[31:0];
  assign w_rem  = r_neg_r ? neg32(w_work_nxt[63:32]) : w_work_nxt[63:32];
`else
  logic w_unused_signed;

  assign w_unused_signed = bus.signed_div_i;
  assign w_dvd_mag       = bus.opdata1_i;
  assign w_dvs_mag       = bus.opdata2_i;
  assign w_quot          = w_work_nxt[31:0];
  assign w_rem           = w_work_nxt[63:32];
`endif

  always_ff @(posedge clk) begin
    if (rst) r_state <= DivFree;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_stall     = 1'b0;
    w_latch     = 1'b0;
    w_iter      = 1'b0;
    w_done      = 1'b0;
    w_zero_done = 1'b0;
    w_release   = 1'b0;
    case (r_state)
      DivFree: begin
        if (w_accept) begin
          w_stall = 1'b1;
          if (bus.opdata2_i == 32'd0) begin
            w_state_nxt = DivByZero;
          end else begin
            w_state_nxt = DivOn;
            w_latch     = 1'b1;
          end
        end
      end
      DivByZero: begin
        w_stall = 1'b1;
        if (bus.annul_i) begin
          w_state_nxt = DivFree;
        end else begin
          w_state_nxt = DivEnd;
          w_zero_done = 1'b1;
        end
      end
      DivOn: begin
        w_stall = 1'b1;
        if (bus.annul_i) begin
          w_state_nxt = DivFree;
        end else begin
          w_iter = 1'b1;
          if (r_cnt == 5'd31) begin
            w_state_nxt = DivEnd;
            w_done      = 1'b1;
          end
        end
      end
      DivEnd: begin
        if (bus.start_i == DivStop) begin
          w_state_nxt = DivFree;
          w_release   = 1'b1;
        end
      end
      default: w_state_nxt = DivFree;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= 5'd0;
      r_work    <= 65'd0;
      r_divisor <= 32'd0;
    end else if (w_latch) begin
      r_cnt     <= 5'd0;
      r_work    <= {33'd0, w_dvd_mag};
      r_divisor <= w_dvs_mag;
    end else if (w_iter) begin
      r_cnt  <= r_cnt + 5'd1;
      r_work <= w_work_nxt;
    end
  end

  // The final iteration's result is signed-corrected on the way into END.
  always_ff @(posedge clk) begin
    if (rst || w_release) begin
      r_result <= 64'd0;
      r_ready  <= DivResultNotReady;
    end else if (w_done) begin
      r_result <= {w_rem, w_quot};
      r_ready  <= DivResultReady;
    end else if (w_zero_done) begin
      r_result <= 64'd0;
      r_ready  <= DivResultReady;
    end
  end

  assign bus.result_o   = r_result;
  assign bus.ready_o    = r_ready;
  assign bus.stallreq_o = w_stall;
endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq: scoreboard of expected {remainder, quotient}
// values, exact latency checks, hold/release, annul and reset scenarios.
module tb_div_seq;
`ifdef DIV_SIGNED_EN
  localparam bit SIGNED_EN = 1'b1;
`else
  localparam bit SIGNED_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  logic [63:0] sb_q[$];

  always #5 clk = ~clk;

  div_seq_if bus ();

  div_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    #300000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk64(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; outputs are sampled 2 later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sgn);
    logic signed [31:0] sa, sb, sq, sr;
    if (b == 32'd0) return 64'd0;
    if (sgn && SIGNED_EN) begin
      sa = a;
      sb = b;
      sq = sa / sb;
      sr = sa % sb;
      return {sr, sq};
    end
    return {a % b, a / b};
  endfunction

  // Called on the first FREE cycle; leaves the DUT in END with start_i held.
  task automatic do_div(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sgn, input int scramble_at);
    int lat;
    int exp_lat;
    sb_q.push_back(model(a, b, sgn));
    bus.opdata1_i    = a;
    bus.opdata2_i    = b;
    bus.signed_div_i = sgn;
    bus.annul_i      = 1'b0;
    bus.start_i      = 1'b1;
    settle();
    chk1({tag, " stall_at_start"}, bus.stallreq_o, 1'b1);
    chk1({tag, " ready_at_start"}, bus.ready_o, 1'b0);
    chk64({tag, " result_at_start"}, bus.result_o, 64'd0);
    lat = 0;
    while (lat < 50) begin
      tick();
      lat++;
      if (lat == scramble_at) begin
        bus.opdata1_i    = $urandom;
        bus.opdata2_i    = $urandom;
        bus.signed_div_i = ~sgn;
      end
      settle();
      if (bus.ready_o === 1'b1) break;
      chk1({tag, " stall_busy"}, bus.stallreq_o, 1'b1);
    end
    exp_lat = (b == 32'd0) ? 2 : 33;
    chk64({tag, " latency"}, 64'(lat), 64'(exp_lat));
    chk1({tag, " stall_at_ready"}, bus.stallreq_o, 1'b0);
    if (sb_q.size() > 0) chk64({tag, " result"}, bus.result_o, sb_q.pop_front());
  endtask

  // Drops start_i from END; returns at the first FREE cycle.
  task automatic release_div(input string tag);
    tick();
    bus.start_i = 1'b0;
    settle();
    chk1({tag, " ready_before_release"}, bus.ready_o, 1'b1);
    tick();
  endtask

  initial begin
    logic [63:0] held;
    logic [31:0] ra, rb;
    logic        rs;
    logic        saw_ready;

    rst              = 1'b1;
    bus.signed_div_i = 1'b0;
    bus.opdata1_i    = 32'd0;
    bus.opdata2_i    = 32'd0;
    bus.start_i      = 1'b0;
    bus.annul_i      = 1'b0;
    repeat (3) tick();
    settle();
    chk1("reset ready", bus.ready_o, 1'b0);
    chk64("reset result", bus.result_o, 64'd0);
    chk1("reset stall", bus.stallreq_o, 1'b0);
    tick();
    rst = 1'b0;
    settle();
    chk1("idle stall", bus.stallreq_o, 1'b0);

    // DIVU 100/7 with operand churn while ON, then hold in END
    tick();
    do_div("divu_100_7", 32'd100, 32'd7, 1'b0, 5);
    chk64("divu_100_7 literal", bus.result_o, {32'd2, 32'd14});
    held = {32'd2, 32'd14};
    repeat (5) begin
      tick();
      settle();
      chk1("hold ready", bus.ready_o, 1'b1);
      chk64("hold result", bus.result_o, held);
    end

    // back-to-back signed divide on the first FREE cycle
    release_div("divu_100_7");
    do_div("div_m7_2", 32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    if (SIGNED_EN) chk64("div_m7_2 literal", bus.result_o, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    else           chk64("div_m7_2 literal", bus.result_o, {32'h0000_0001, 32'h7FFF_FFFC});

    release_div("div_m7_2");
    do_div("by_zero", 32'd5, 32'd0, 1'b0, 0);
    chk64("by_zero literal", bus.result_o, 64'd0);

    release_div("by_zero");
    settle();
    chk1("released ready", bus.ready_o, 1'b0);
    chk64("released result", bus.result_o, 64'd0);
    chk1("released stall", bus.stallreq_o, 1'b0);

    // annul in the 10th cycle after start
    tick();
    bus.opdata1_i = 32'd100;
    bus.opdata2_i = 32'd7;
    bus.start_i   = 1'b1;
    repeat (10) tick();
    bus.annul_i = 1'b1;
    bus.start_i = 1'b0;
    settle();
    chk1("annul stall_in_on", bus.stallreq_o, 1'b1);
    tick();
    bus.annul_i = 1'b0;
    settle();
    chk1("annul stall_after", bus.stallreq_o, 1'b0);
    chk1("annul ready_after", bus.ready_o, 1'b0);
    saw_ready = 1'b0;
    repeat (40) begin
      tick();
      settle();
      saw_ready = saw_ready | bus.ready_o;
    end
    chk1("annul ready_never", saw_ready, 1'b0);

    // reset in the 15th cycle after start
    tick();
    bus.start_i = 1'b1;
    repeat (15) tick();
    rst         = 1'b1;
    bus.start_i = 1'b0;
    tick();
    rst = 1'b0;
    settle();
    chk1("rst_mid ready", bus.ready_o, 1'b0);
    chk64("rst_mid result", bus.result_o, 64'd0);
    chk1("rst_mid stall", bus.stallreq_o, 1'b0);
    tick();
    do_div("divu_9_3", 32'd9, 32'd3, 1'b0, 0);
    chk64("divu_9_3 literal", bus.result_o, {32'd0, 32'd3});

    for (int i = 0; i < 6; i++) begin
      release_div("rand");
      ra = $urandom;
      rb = $urandom >> $urandom_range(31, 0);
      rs = 1'($urandom_range(1, 0));
      if (rb == 32'd0) rb = 32'd1;
      if (ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF) rb = 32'd3;
      do_div("rand", ra, rb, rs, 7);
    end

    release_div("final");
    settle();
    chk64("scoreboard empty", 64'(sb_q.size()), 64'd0);
    chk1("final ready", bus.ready_o, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
